// File: rtl/multi_port_gpr_pkg.sv
// Shared register-file constants, also used by decode and writeback.
package multi_port_gpr_pkg;

  localparam int GPR_DW   = 32;
  localparam int GPR_AW   = 5;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/multi_port_gpr_if.sv
// Decode/writeback-facing bus of the register file; flat per-port vectors.
interface multi_port_gpr_if
  import multi_port_gpr_pkg::*;
#(
  parameter int DW  = GPR_DW,
  parameter int AW  = GPR_AW,
  parameter int NRD = 3,
  parameter int NWR = 2
);

  logic              i_clr;
  logic [NRD*AW-1:0] i_raddr;
  logic [NRD*DW-1:0] o_rdata;
  logic [NWR-1:0]    i_wen;
  logic [NWR*AW-1:0] i_wreg;
  logic [NWR*DW-1:0] i_wdata;
  logic              o_busy;
  logic              o_wdrop;

  modport master (
    output i_clr, i_raddr, i_wen, i_wreg, i_wdata,
    input  o_rdata, o_busy, o_wdrop
  );

  modport slave (
    input  i_clr, i_raddr, i_wen, i_wreg, i_wdata,
    output o_rdata, o_busy, o_wdrop
  );

endinterface

// File: rtl/multi_port_gpr_clear_seq.sv
// Clear sequencer: walks every entry from 0 to DEPTH-1, one per cycle.
//   state    | meaning
//   CLR_IDLE | storage usable, no clear in progress
//   CLR_RUN  | zeroing mem[cnt]; restarts from 0 on rst or i_clr
module gpr_clear_seq
  import multi_port_gpr_pkg::*;
#(
  parameter int AW = GPR_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  clr_state_e    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      state <= CLR_RUN;
      cnt   <= '0;
    end else if (state == CLR_RUN) begin
      // counter parks on the last entry rather than wrapping
      if (cnt == LAST_ADDR) begin
        state <= CLR_IDLE;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  assign o_busy     = (state == CLR_RUN);
  assign o_clr_we   = o_busy & ~rst;
  assign o_clr_addr = cnt;

endmodule

// File: rtl/multi_port_gpr.sv
// Multi-port GPR file: async reads with same-cycle bypass, prioritised writes,
// hardwired zero register and a self-clearing storage array.
module multi_port_gpr
  import multi_port_gpr_pkg::*;
#(
  parameter int DW  = GPR_DW,
  parameter int AW  = GPR_AW,
  parameter int NRD = 3,
  parameter int NWR = 2
) (
  input  logic           clk,
  input  logic           rst,
  multi_port_gpr_if.slave bus
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DW-1:0] mem [DEPTH];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          write_blocked;
  logic          wdrop;

  logic [AW-1:0]    waddr [NWR];
  logic [DW-1:0]    wdata [NWR];
  logic [NWR-1:0]   wr_hit;
  logic [NRD*DW-1:0] rdata;

  gpr_clear_seq #(.AW(AW)) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (bus.i_clr),
    .o_busy     (busy),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr)
  );

  // a write only counts when enabled and aimed at a real (nonzero) register
  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign waddr[j]  = bus.i_wreg[j*AW +: AW];
    assign wdata[j]  = bus.i_wdata[j*DW +: DW];
    assign wr_hit[j] = bus.i_wen[j] && (waddr[j] != ZERO_ADDR);
  end

  assign write_blocked = busy | bus.i_clr | rst;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (!write_blocked) begin
      // later ports overwrite earlier ones, giving the higher index priority
      for (int j = 0; j < NWR; j++) begin
        if (wr_hit[j]) begin
          mem[waddr[j]] <= wdata[j];
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    assign ra = bus.i_raddr[k*AW +: AW];

    always_comb begin
      rd = '0;
      if (!busy && (ra != ZERO_ADDR)) begin
        rd = mem[ra];
        for (int j = 0; j < NWR; j++) begin
          if (wr_hit[j] && (waddr[j] == ra)) begin
            rd = wdata[j];
          end
        end
      end
    end

    assign rdata[k*DW +: DW] = rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdrop <= 1'b0;
    end else begin
      wdrop <= (busy | bus.i_clr) & (|wr_hit);
    end
  end

  assign bus.o_rdata = rdata;
  assign bus.o_busy  = busy;
  assign bus.o_wdrop = wdrop;

endmodule

// File: tb/tb_multi_port_gpr.sv
// Scoreboard bench for multi_port_gpr: expected read data queued with stimulus.
module tb_multi_port_gpr;
  import multi_port_gpr_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 3;
  localparam int NWR = 2;

  typedef struct {
    int            port;
    int            addr;
    logic [DW-1:0] data;
    string         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  multi_port_gpr_if #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) bus ();

  multi_port_gpr #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_wen = '0;
    bus.i_clr = 1'b0;
  endtask

  task automatic put_write(input int port, input int addr, input logic [DW-1:0] data);
    bus.i_wen[port]             = 1'b1;
    bus.i_wreg[port*AW +: AW]   = AW'(addr);
    bus.i_wdata[port*DW +: DW]  = data;
  endtask

  task automatic put_read(input int port, input int addr, input logic [DW-1:0] data,
                          input string tag);
    exp_t e;
    bus.i_raddr[port*AW +: AW] = AW'(addr);
    e.port = port;
    e.addr = addr;
    e.data = data;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    int   n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.o_wdrop !== 1'b0) begin
      errors++;
      $display("FAIL reset_wdrop got %b want 0", bus.o_wdrop);
    end
    n = 0;
    while (bus.o_busy === 1'b1 && n < 200) begin
      n++;
      for (int k = 0; k < NRD; k++) put_read(k, (n + 11 * k) % 32, '0, "reset_busy_rd");
      #1;
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
          errors++;
          $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                   bus.o_rdata[e.port*DW +: DW], e.data);
        end
      end
      tick();
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL reset_busy_len got %0d want 32", n);
    end
    for (int a = 0; a < 32; a++) begin
      put_read(a % NRD, a, '0, "reset_all_zero");
      if ((a % NRD) == NRD - 1 || a == 31) begin
        #1;
        while (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checks++;
          if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
            errors++;
            $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                     bus.o_rdata[e.port*DW +: DW], e.data);
          end
        end
      end
    end
  endtask

  task automatic test_writes();
    exp_t e;
    put_write(0, 5, 32'hDEADBEEF);
    tick();
    idle_inputs();
    put_write(1, 7, 32'h12345678);
    tick();
    idle_inputs();
    checks++;
    if (bus.o_wdrop !== 1'b0) begin
      errors++;
      $display("FAIL writes_wdrop got %b want 0", bus.o_wdrop);
    end
    put_read(0, 5, 32'hDEADBEEF, "writes_r5");
    put_read(1, 7, 32'h12345678, "writes_r7");
    put_read(2, 0, 32'h0, "writes_r0");
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
        errors++;
        $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                 bus.o_rdata[e.port*DW +: DW], e.data);
      end
    end
  endtask

  task automatic test_conflict_r0();
    exp_t e;
    put_write(0, 9, 32'h11);
    put_write(1, 9, 32'h22);
    tick();
    idle_inputs();
    checks++;
    if (bus.o_wdrop !== 1'b0) begin
      errors++;
      $display("FAIL conflict_wdrop got %b want 0", bus.o_wdrop);
    end
    put_write(1, 0, 32'hFF);
    tick();
    idle_inputs();
    checks++;
    if (bus.o_wdrop !== 1'b0) begin
      errors++;
      $display("FAIL r0_wdrop got %b want 0", bus.o_wdrop);
    end
    put_read(0, 9, 32'h22, "conflict_r9");
    put_read(1, 0, 32'h0, "r0_read");
    put_read(2, 9, 32'h22, "conflict_r9_p2");
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
        errors++;
        $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                 bus.o_rdata[e.port*DW +: DW], e.data);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    put_write(0, 3, 32'h1);
    tick();
    idle_inputs();
    put_write(1, 3, 32'hCAFE);
    put_read(2, 3, 32'hCAFE, "bypass_p2_r3");
    put_read(0, 3, 32'hCAFE, "bypass_p0_r3");
    put_read(1, 5, 32'hDEADBEEF, "bypass_other_r5");
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
        errors++;
        $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                 bus.o_rdata[e.port*DW +: DW], e.data);
      end
    end
    tick();
    idle_inputs();
    put_write(0, 10, 32'hAAAA);
    put_write(1, 10, 32'hBBBB);
    put_read(0, 10, 32'hBBBB, "bypass_prio_r10");
    put_read(2, 3, 32'hCAFE, "bypass_stored_r3");
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
        errors++;
        $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                 bus.o_rdata[e.port*DW +: DW], e.data);
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_clear_restart();
    exp_t e;
    int   n;
    for (int a = 1; a < 32; a += 2) begin
      put_write(0, a, 32'hA5000000 | a);
      if (a + 1 < 32) put_write(1, a + 1, 32'hA5000000 | (a + 1));
      tick();
      idle_inputs();
    end
    put_read(0, 1, 32'hA5000001, "fill_r1");
    put_read(1, 17, 32'hA5000011, "fill_r17");
    put_read(2, 31, 32'hA500001F, "fill_r31");
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
        errors++;
        $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                 bus.o_rdata[e.port*DW +: DW], e.data);
      end
    end
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    n = 0;
    while (bus.o_busy === 1'b1 && n < 200) begin
      n++;
      bus.i_clr = (n == 10);
      tick();
    end
    bus.i_clr = 1'b0;
    checks++;
    if (n !== 42) begin
      errors++;
      $display("FAIL clear_restart_len got %0d want 42", n);
    end
    for (int a = 0; a < 32; a++) begin
      put_read(a % NRD, a, '0, "clear_all_zero");
      if ((a % NRD) == NRD - 1 || a == 31) begin
        #1;
        while (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checks++;
          if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
            errors++;
            $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                     bus.o_rdata[e.port*DW +: DW], e.data);
          end
        end
      end
    end
  endtask

  task automatic test_drop();
    exp_t e;
    int   n;
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy_start got %b want 1", bus.o_busy);
    end
    repeat (10) tick();
    put_write(0, 4, 32'h55);
    put_read(1, 4, 32'h0, "drop_no_bypass");
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
        errors++;
        $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                 bus.o_rdata[e.port*DW +: DW], e.data);
      end
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.o_wdrop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse got %b want 1", bus.o_wdrop);
    end
    tick();
    checks++;
    if (bus.o_wdrop !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse_end got %b want 0", bus.o_wdrop);
    end
    n = 0;
    while (bus.o_busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy_timeout got %b want 0", bus.o_busy);
    end
    put_read(0, 4, 32'h0, "drop_r4_zero");
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.o_rdata[e.port*DW +: DW] !== e.data) begin
        errors++;
        $display("FAIL %s port %0d addr %0d got %h want %h", e.tag, e.port, e.addr,
                 bus.o_rdata[e.port*DW +: DW], e.data);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.i_clr    = 1'b0;
    bus.i_raddr  = '0;
    bus.i_wen    = '0;
    bus.i_wreg   = '0;
    bus.i_wdata  = '0;
    test_reset();
    test_writes();
    test_conflict_r0();
    test_bypass();
    test_clear_restart();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
